// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// start/busy/done handshake, result held in a product register.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg;
    logic [PW-1:0]     acc_reg;
    logic [PW-1:0]     mcand_reg;
    logic [WIDTH-1:0]  mplier_reg;
    logic [CW-1:0]     cnt_reg;
    logic [PW-1:0]     product_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [PW-1:0]     sum;
    logic [PW-1:0]     carry;
    logic [PW-1:0]     acc_next;

    // Ripple-carry chain; the top stage only forms its sum bit, the carry-out is dropped.
    assign carry[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_add
            if (gi < PW - 1) begin : g_fa
                full_adder u_fa (
                    .x    (acc_reg[gi]),
                    .y    (mcand_reg[gi]),
                    .cin  (carry[gi]),
                    .s    (sum[gi]),
                    .cout (carry[gi+1])
                );
            end else begin : g_msb
                assign sum[gi] = acc_reg[gi] ^ mcand_reg[gi] ^ carry[gi];
            end
        end
    endgenerate

    assign acc_next = mplier_reg[0] ? sum : acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (start) begin
                        acc_reg    <= '0;
                        mcand_reg  <= {{WIDTH{1'b0}}, a};
                        mplier_reg <= b;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    // Last bit: latch the result including this cycle's add.
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        product_reg <= acc_next;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=4): latency, holding,
// start-while-busy, back-to-back, asynchronous reset and an exhaustive sweep.

module tb_shift_add_multiplier;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE; returns at the negedge of the done cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [2*W-1:0] exp, input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 16'(lat), 16'(W + 1));
        check({tag, " product"}, 16'(product), 16'(exp));
    endtask

    initial begin
        int dones;
        int bad;
        int k;
        logic [2*W-1:0] got;

        // Reset state
        #2;
        check("reset busy", 16'(busy), 16'h0);
        check("reset done", 16'(done), 16'h0);
        check("reset product", 16'(product), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 15 x 15 with cycle-by-cycle handshake checks
        @(negedge clk);
        start = 1'b1; a = 4'd15; b = 4'd15;
        @(negedge clk);
        start = 1'b0;
        check("15x15 busy after accept", 16'(busy), 16'h1);
        check("15x15 no early done", 16'(done), 16'h0);
        k = 1;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("15x15 latency", 16'(k), 16'(W + 1));
        check("15x15 product", 16'(product), 16'h00E1);
        check("15x15 busy in done", 16'(busy), 16'h1);
        @(negedge clk);
        check("15x15 busy cleared", 16'(busy), 16'h0);
        check("15x15 done single pulse", 16'(done), 16'h0);
        check("15x15 product held", 16'(product), 16'h00E1);

        // Fixed latency regardless of operand values
        run_op(4'd7, 4'd3, 8'h15, "7x3");
        run_op(4'd0, 4'd9, 8'h00, "0x9");
        run_op(4'd9, 4'd0, 8'h00, "9x0");

        // start pulsed while busy with other operands is ignored
        @(negedge clk);
        start = 1'b1; a = 4'd5; b = 4'd6;
        dones = 0;
        got = '0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                got = product;
            end
            if (i <= 4) begin
                start = 1'b1; a = 4'(i + 10); b = 4'(15 - i);
            end else begin
                start = 1'b0;
            end
        end
        check("busy-ignore done count", 16'(dones), 16'h1);
        check("busy-ignore product", 16'(got), 16'h001E);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; a = 4'd3; b = 4'd4;
        bad = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a = 4'd2; b = 4'd8;
            end
            if (i == 5 || i == 11) begin
                check($sformatf("b2b done at cycle %0d", i), 16'(done), 16'h1);
                check($sformatf("b2b product at cycle %0d", i), 16'(product),
                      (i == 5) ? 16'd12 : 16'd16);
            end else if (done === 1'b1) begin
                bad++;
            end
            if (i >= 6 && i <= 10 && product !== 8'd12)
                bad++;
            if (i == 11)
                start = 1'b0;
        end
        check("b2b stray done or product change", 16'(bad), 16'h0);

        // Asynchronous reset in the third RUN cycle
        @(negedge clk);
        start = 1'b1; a = 4'd15; b = 4'd15;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", 16'(busy), 16'h0);
        check("async rst done", 16'(done), 16'h0);
        check("async rst product", 16'(product), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0)
                bad++;
        end
        check("no resume after reset", 16'(bad), 16'h0);
        run_op(4'd2, 4'd3, 8'd6, "2x3 after reset");

        // Exhaustive sweep against the arithmetic reference
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), 8'(i * j), $sformatf("sweep %0dx%0d", i, j));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
